// File: rtl/out_fifo_arbiter.sv
// Packet-aware round-robin arbiter: OutFifo (src 0) + OutRegFifo (src 1)
// -> one 32-bit valid/ready stream. Timeout/length guards, sticky errors.
module out_fifo_arbiter #(
  parameter logic [31:0] FOOTER_MASK    = 32'hFFFF0000,
  parameter logic [31:0] FOOTER_VALUE   = 32'hEE1D0000,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_PKT_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Src0Data,
  input  logic        Src0Empty,
  output logic        Src0ReadAck,
  input  logic [31:0] Src1Data,
  input  logic        Src1Empty,
  output logic        Src1ReadAck,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_src,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic        err_overlength,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic        busy
);

  localparam int WCW = $clog2(MAX_PKT_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    DRAIN
  } state_t;

  state_t state, stateNxt;

  logic           lastGrant;
  logic [WCW-1:0] wordCnt;
  logic [TCW-1:0] toCnt;

  logic [31:0] outData;
  logic        outValid;
  logic        outSrc;
  logic        outSop;
  logic        outEop;
  logic        errTo;
  logic        errOvl;
  logic [15:0] pktCnt0;
  logic [15:0] pktCnt1;

  logic           gSel;
  logic           granted;
  logic           selEmpty;
  logic [31:0]    selData;
  logic           canLoad;
  logic           load;
  logic           isFooter;
  logic [WCW-1:0] wordInc;
  logic           hitMax;
  logic           overLen;
  logic           footDone;
  logic           timedOut;

  assign gSel     = (state == GRANT1);
  assign granted  = (state == GRANT0) || (state == GRANT1);
  assign selEmpty = gSel ? Src1Empty : Src0Empty;
  assign selData  = gSel ? Src1Data : Src0Data;
  assign canLoad  = !outValid || out_ready;
  assign load     = granted && !selEmpty && canLoad;
  assign isFooter = (selData & FOOTER_MASK) == FOOTER_VALUE;
  assign wordInc  = wordCnt + 1'b1;
  assign hitMax   = (wordInc == WCW'(MAX_PKT_WORDS));
  assign overLen  = load && hitMax && !isFooter;
  assign footDone = load && isFooter;
  assign timedOut = granted && selEmpty &&
                    (toCnt == TCW'(TIMEOUT_CYCLES - 1));

  assign Src0ReadAck = load && !gSel;
  assign Src1ReadAck = load && gSel;

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (!Src0Empty && !Src1Empty)
          stateNxt = lastGrant ? GRANT0 : GRANT1;
        else if (!Src0Empty)
          stateNxt = GRANT0;
        else if (!Src1Empty)
          stateNxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (footDone || overLen || timedOut)
          stateNxt = DRAIN;
      end
      DRAIN: begin
        if (canLoad)
          stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      wordCnt   <= '0;
      toCnt     <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
      outSrc    <= 1'b0;
      outSop    <= 1'b0;
      outEop    <= 1'b0;
      errTo     <= 1'b0;
      errOvl    <= 1'b0;
      pktCnt0   <= '0;
      pktCnt1   <= '0;
    end else begin
      state <= stateNxt;

      if (state == IDLE && stateNxt != IDLE)
        lastGrant <= (stateNxt == GRANT1);

      if (state == IDLE) begin
        wordCnt <= '0;
        toCnt   <= '0;
      end else if (load) begin
        wordCnt <= wordInc;
        toCnt   <= '0;
      end else if (granted && selEmpty) begin
        toCnt <= toCnt + 1'b1;
      end

      if (load) begin
        outData  <= selData;
        outValid <= 1'b1;
        outSrc   <= gSel;
        outSop   <= (wordCnt == '0);
        outEop   <= isFooter || hitMax;
      end else if (out_ready) begin
        outValid <= 1'b0;
      end

      if (footDone) begin
        if (gSel) pktCnt1 <= pktCnt1 + 1'b1;
        else      pktCnt0 <= pktCnt0 + 1'b1;
      end

      // set wins over a simultaneous clear
      if (timedOut)       errTo <= 1'b1;
      else if (err_clear) errTo <= 1'b0;

      if (overLen)        errOvl <= 1'b1;
      else if (err_clear) errOvl <= 1'b0;
    end
  end

  assign out_data       = outData;
  assign out_valid      = outValid;
  assign out_src        = outSrc;
  assign out_sop        = outSop;
  assign out_eop        = outEop;
  assign err_timeout    = errTo;
  assign err_overlength = errOvl;
  assign pkt_cnt0       = pktCnt0;
  assign pkt_cnt1       = pktCnt1;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// Bench for out_fifo_arbiter: queue-based FIFOs, expected-beat scoreboard,
// protocol checks every cycle plus directed literal checks.
module tb_out_fifo_arbiter;

  localparam logic [31:0] FMASK = 32'hFFFF0000;
  localparam logic [31:0] FVAL  = 32'hEE1D0000;
  localparam int          MAXW  = 4096;
  localparam int          TOC   = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Src0Data, Src1Data;
  logic        Src0Empty, Src1Empty;
  logic        Src0ReadAck, Src1ReadAck;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_src, out_sop, out_eop;
  logic        err_clear, err_timeout, err_overlength;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic        busy;

  always #5 clk = ~clk;

  out_fifo_arbiter #(
    .FOOTER_MASK(FMASK),
    .FOOTER_VALUE(FVAL),
    .TIMEOUT_CYCLES(TOC),
    .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Src0Data(Src0Data),
    .Src0Empty(Src0Empty),
    .Src0ReadAck(Src0ReadAck),
    .Src1Data(Src1Data),
    .Src1Empty(Src1Empty),
    .Src1ReadAck(Src1ReadAck),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src(out_src),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .err_clear(err_clear),
    .err_timeout(err_timeout),
    .err_overlength(err_overlength),
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [34:0] expQ[$];

  int   ackCnt0 = 0;
  int   ackCnt1 = 0;
  int   ncyc = 0;
  int   gapCnt = 0;
  int   lastGap = -1;
  logic toArm = 1'b0;
  int   toAckCyc = -1;
  logic prevStall = 1'b0;
  logic [34:0] prevWord;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    Src0Empty = (q0.size() == 0);
    Src1Empty = (q1.size() == 0);
    Src0Data  = (q0.size() != 0) ? q0[0] : 32'h0;
    Src1Data  = (q1.size() != 0) ? q1[0] : 32'h0;
  endtask

  task automatic fifoPush(int src, logic [31:0] d);
    if (src == 0) q0.push_back(d);
    else          q1.push_back(d);
  endtask

  // expected beat from the packet rules: sop on first word,
  // eop on footer or on the word that reaches the length limit
  task automatic expPush(int src, logic [31:0] d, int idx);
    logic sop, eop;
    sop = (idx == 0);
    eop = ((d & FMASK) == FVAL) || (idx + 1 == MAXW);
    expQ.push_back({src[0], sop, eop, d});
  endtask

  task automatic addWord(int src, logic [31:0] d, int idx);
    fifoPush(src, d);
    expPush(src, d, idx);
  endtask

  task automatic tick();
    logic a0, a1;
    @(negedge clk);
    a0 = Src0ReadAck;
    a1 = Src1ReadAck;
    @(posedge clk);
    #2;
    if (a0 && q0.size() != 0) q0.delete(0);
    if (a1 && q1.size() != 0) q1.delete(0);
    drive();
  endtask

  task automatic runDrain(string name, int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((expQ.size() != 0 || busy || out_valid ||
                q0.size() != 0 || q1.size() != 0) && n < bound);
    chk(name, (n < bound), 1);
  endtask

  // compare process: every cycle, sampled at the negedge
  always @(negedge clk) begin
    logic [34:0] e;
    ncyc++;
    if (!reset) begin
      prevStall = 1'b0;
    end else begin
      if (toArm && toAckCyc < 0 && Src1ReadAck) toAckCyc = ncyc;
      if (Src0ReadAck) ackCnt0++;
      if (Src1ReadAck) ackCnt1++;
      if (Src0ReadAck || Src1ReadAck) begin
        chk("two_acks", Src0ReadAck && Src1ReadAck, 0);
        chk("ack_empty", (Src0ReadAck && Src0Empty) ||
                         (Src1ReadAck && Src1Empty), 0);
        chk("ack_stalled", out_valid && !out_ready, 0);
      end
      if (prevStall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_src, out_sop, out_eop, out_data}, prevWord);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          chk("extra_beat", out_data, 32'hDEADBEEF);
        end else begin
          e = expQ.pop_front();
          chk("beat", {out_src, out_sop, out_eop, out_data}, e);
        end
        if (out_sop) lastGap = gapCnt;
        if (out_eop) gapCnt = 0;
      end
      if (!busy) gapCnt++;
      prevStall = out_valid && !out_ready;
      prevWord  = {out_src, out_sop, out_eop, out_data};
      if (toArm && toAckCyc >= 0) begin
        if (ncyc == toAckCyc + TOC)
          chk("timeout_early", err_timeout, 0);
        if (ncyc == toAckCyc + TOC + 1) begin
          chk("timeout_at", err_timeout, 1);
          toArm = 1'b0;
        end
      end
    end
  end

  task automatic doReset();
    reset = 1'b0;
    expQ.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    err_clear = 1'b0;
    drive();
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
    chk("rst_err", {err_timeout, err_overlength}, 0);
    tick();
    reset = 1'b1;

    // single source, 3-word packet
    ackCnt0 = 0;
    addWord(0, 32'h12340001, 0);
    addWord(0, 32'h00000005, 1);
    addWord(0, 32'hEE1D0003, 2);
    drive();
    runDrain("drain_t1", 50);
    chk("t1_pkt0", pkt_cnt0, 1);
    chk("t1_pkt1", pkt_cnt1, 0);
    chk("t1_acks", ackCnt0, 3);

    // tie after reset: src0 first, then src1
    doReset();
    chk("t2_pkt0_rst", pkt_cnt0, 0);
    addWord(0, 32'hA0000001, 0);
    addWord(0, 32'hEE1D0011, 1);
    addWord(1, 32'hB0000001, 0);
    addWord(1, 32'hEE1D0022, 1);
    drive();
    runDrain("drain_t2", 50);
    chk("t2_gap", lastGap, 1);
    chk("t2_pkt0", pkt_cnt0, 1);
    chk("t2_pkt1", pkt_cnt1, 1);
    addWord(0, 32'hEE1D0033, 0);
    addWord(1, 32'hC0000000, 0);
    addWord(1, 32'hEE1D0044, 1);
    drive();
    runDrain("drain_t2b", 50);
    chk("t2b_pkt0", pkt_cnt0, 2);
    chk("t2b_pkt1", pkt_cnt1, 2);

    // backpressure 1,0,0,1
    for (int i = 0; i < 4; i++)
      addWord(0, 32'h00000001 + i, i);
    addWord(0, 32'hEE1D00FF, 4);
    drive();
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      tick();
    end
    out_ready = 1'b1;
    runDrain("drain_t3", 50);
    chk("t3_pkt0", pkt_cnt0, 3);

    // src1 header then starve -> timeout; src0 waits
    toAckCyc = -1;
    toArm = 1'b1;
    addWord(1, 32'h12340000, 0);
    drive();
    for (int i = 0; i < 10; i++) tick();
    addWord(0, 32'h00000005, 0);
    addWord(0, 32'hEE1D0055, 1);
    drive();
    runDrain("drain_t4", 1400);
    chk("t4_seen", toArm, 0);
    chk("t4_err", err_timeout, 1);
    chk("t4_pkt1", pkt_cnt1, 2);
    chk("t4_pkt0", pkt_cnt0, 4);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    chk("t4_clear", err_timeout, 0);

    // overlength
    for (int i = 0; i < MAXW; i++)
      addWord(0, 32'h00AB0000 | i, i);
    drive();
    runDrain("drain_t5", 5000);
    chk("t5_ovl", err_overlength, 1);
    chk("t5_to", err_timeout, 0);
    chk("t5_pkt0", pkt_cnt0, 4);

    // reset mid-packet, FIFO keeps its remaining words
    out_ready = 1'b0;
    fifoPush(1, 32'h00000100);
    fifoPush(1, 32'h00000200);
    fifoPush(1, 32'h00000300);
    fifoPush(1, 32'hEE1D0004);
    expPush(1, 32'h00000100, 0);
    drive();
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("t6_loaded", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_acks", {Src0ReadAck, Src1ReadAck}, 0);
    expQ.delete();
    tick();
    reset = 1'b1;
    chk("t6_cnt", {pkt_cnt0, pkt_cnt1}, 0);
    chk("t6_err", err_overlength, 0);
    expPush(1, 32'h00000200, 0);
    expPush(1, 32'h00000300, 1);
    expPush(1, 32'hEE1D0004, 2);
    out_ready = 1'b1;
    runDrain("drain_t6", 50);
    chk("t6_pkt1", pkt_cnt1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
